// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared CNN helpers: saturation bounds, CHW linear indexing and
//               address-width sizing used by the conv and pooling stages.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

   // Address width for a memory of `size` words; never narrower than one bit.
   function automatic int addr_w(input int size);
      return (size <= 1) ? 1 : $clog2(size);
   endfunction

   // Most negative value of a signed sample of width w.
   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

   // Most positive value of a signed sample of width w.
   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   // CHW linear index of element (ch, row, col) in a map of h rows by w cols.
   function automatic int lin3(input int ch, input int row, input int col,
                               input int h, input int w);
      return (ch * h + row) * w + col;
   endfunction

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/relu_maxpool2d.sv
`default_nettype none
// ============================================================================
// Module      : relu_maxpool2d
// Description : Non-overlapping POOLxPOOL max-pool over a CHW feature map held
//               in a synchronous-read BRAM, writing the pooled CHW map to a
//               second BRAM. Define RELU_MAXPOOL_RELU_EN to clamp negative
//               pooled results to zero (fused ReLU); timing is unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_maxpool2d
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 8,
   parameter int IMG_SIZE   = 28,
   parameter int POOL       = 2
) (
   input  logic                                                        clk,
   input  logic                                                        reset,
   input  logic                                                        start,
   output logic [addr_w(CHANNELS*IMG_SIZE*IMG_SIZE)-1:0]               in_addr,
   output logic                                                        in_en,
   input  logic signed [DATA_WIDTH-1:0]                                in_q,
   output logic [addr_w(CHANNELS*(IMG_SIZE/POOL)*(IMG_SIZE/POOL))-1:0] out_addr,
   output logic                                                        out_en,
   output logic                                                        out_we,
   output logic signed [DATA_WIDTH-1:0]                                out_d,
   output logic                                                        done,
   output logic                                                        busy
);

   localparam int c_out_size = IMG_SIZE / POOL;
   localparam int c_in_aw    = addr_w(CHANNELS * IMG_SIZE * IMG_SIZE);
   localparam int c_out_aw   = addr_w(CHANNELS * c_out_size * c_out_size);
   localparam int c_cw       = addr_w(CHANNELS);
   localparam int c_ow       = addr_w(c_out_size);
   localparam int c_pw       = addr_w(POOL);
   localparam logic signed [DATA_WIDTH-1:0] c_s_min = DATA_WIDTH'(sat_min(DATA_WIDTH));

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_read   = 3'd1;
   localparam logic [2:0] c_st_wait   = 3'd2;
   localparam logic [2:0] c_st_cap    = 3'd3;
   localparam logic [2:0] c_st_write  = 3'd4;
   localparam logic [2:0] c_st_finish = 3'd5;

   logic [2:0]                   r_state;
   logic [2:0]                   w_next;
   logic [c_cw-1:0]              r_c;
   logic [c_ow-1:0]              r_orow;
   logic [c_ow-1:0]              r_ocol;
   logic [c_pw-1:0]              r_pr;
   logic [c_pw-1:0]              r_pc;
   logic signed [DATA_WIDTH-1:0] r_max;
   logic signed [DATA_WIDTH-1:0] r_stage;
   logic signed [DATA_WIDTH-1:0] w_cap_max;
   logic signed [DATA_WIDTH-1:0] w_stage;
   logic                         w_pc_last;
   logic                         w_tap_last;
   logic                         w_ocol_last;
   logic                         w_orow_last;
   logic                         w_c_last;
   logic                         w_pix_last;
   logic                         w_in_en;
   logic                         w_out_we;
   logic                         w_done;

   assign w_pc_last   = (int'(r_pc) == POOL - 1);
   assign w_tap_last  = w_pc_last && (int'(r_pr) == POOL - 1);
   assign w_ocol_last = (int'(r_ocol) == c_out_size - 1);
   assign w_orow_last = (int'(r_orow) == c_out_size - 1);
   assign w_c_last    = (int'(r_c) == CHANNELS - 1);
   assign w_pix_last  = w_ocol_last && w_orow_last && w_c_last;

   // Strictly greater keeps the earlier maximum on ties.
   assign w_cap_max = (in_q > r_max) ? in_q : r_max;

`ifdef RELU_MAXPOOL_RELU_EN
   assign w_stage = w_cap_max[DATA_WIDTH-1] ? '0 : w_cap_max;
`else
   assign w_stage = w_cap_max;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= c_st_idle;
      else       r_state <= w_next;
   end

   // Next-state decode: READ -> WAIT -> CAP per tap, WRITE per output pixel.
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_st_idle:   if (start) w_next = c_st_read;
         c_st_read:   w_next = c_st_wait;
         c_st_wait:   w_next = c_st_cap;
         c_st_cap:    w_next = w_tap_last ? c_st_write : c_st_read;
         c_st_write:  w_next = w_pix_last ? c_st_finish : c_st_read;
         c_st_finish: w_next = c_st_idle;
         default:     w_next = c_st_idle;
      endcase
   end

   // Output strobe decode; registered below so the ports come straight from flops.
   always_comb begin
      w_in_en  = (r_state == c_st_read);
      w_out_we = (r_state == c_st_write);
      w_done   = (r_state == c_st_finish);
   end

   // Port registers: strobes default low, addresses/data load only when strobed.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_en    <= 1'b0;
         out_en   <= 1'b0;
         out_we   <= 1'b0;
         done     <= 1'b0;
         in_addr  <= '0;
         out_addr <= '0;
         out_d    <= '0;
      end else begin
         in_en  <= w_in_en;
         out_en <= w_out_we;
         out_we <= w_out_we;
         done   <= w_done;
         if (w_in_en) begin
            in_addr <= c_in_aw'(lin3(int'(r_c),
                                     int'(r_orow) * POOL + int'(r_pr),
                                     int'(r_ocol) * POOL + int'(r_pc),
                                     IMG_SIZE, IMG_SIZE));
         end
         if (w_out_we) begin
            out_addr <= c_out_aw'(lin3(int'(r_c), int'(r_orow), int'(r_ocol),
                                       c_out_size, c_out_size));
            out_d    <= r_stage;
         end
      end
   end

   // Loop counters, running maximum, staged result and busy flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_c     <= '0;
         r_orow  <= '0;
         r_ocol  <= '0;
         r_pr    <= '0;
         r_pc    <= '0;
         r_max   <= c_s_min;
         r_stage <= '0;
         busy    <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               // busy stays high through the done cycle and drops here.
               busy <= start;
               if (start) begin
                  r_c    <= '0;
                  r_orow <= '0;
                  r_ocol <= '0;
                  r_pr   <= '0;
                  r_pc   <= '0;
                  r_max  <= c_s_min;
               end
            end
            c_st_cap: begin
               r_max <= w_cap_max;
               if (w_pc_last) begin
                  r_pc <= '0;
                  r_pr <= w_tap_last ? '0 : r_pr + 1'b1;
               end else begin
                  r_pc <= r_pc + 1'b1;
               end
               if (w_tap_last) r_stage <= w_stage;
            end
            c_st_write: begin
               r_max <= c_s_min;
               if (w_ocol_last) begin
                  r_ocol <= '0;
                  if (w_orow_last) begin
                     r_orow <= '0;
                     r_c    <= w_c_last ? '0 : r_c + 1'b1;
                  end else begin
                     r_orow <= r_orow + 1'b1;
                  end
               end else begin
                  r_ocol <= r_ocol + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : relu_maxpool2d
`default_nettype wire

// File: tb/tb_relu_maxpool2d.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu_maxpool2d
// Description : Directed self-checking bench for relu_maxpool2d. Two instances:
//               A = 1 channel, 4x4, pool 2; B = 2 channels, 5x5, pool 2.
//               Expected values follow RELU_MAXPOOL_RELU_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool2d;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start_a, start_b, clr;

   logic [3:0]         in_addr_a;
   logic               in_en_a;
   logic signed [15:0] q_a;
   logic [1:0]         out_addr_a;
   logic               out_en_a, out_we_a, done_a, busy_a;
   logic signed [15:0] out_d_a;

   logic [5:0]         in_addr_b;
   logic               in_en_b;
   logic signed [15:0] q_b;
   logic [2:0]         out_addr_b;
   logic               out_en_b, out_we_b, done_b, busy_b;
   logic signed [15:0] out_d_b;

   logic signed [15:0] mem_a [16];
   logic signed [15:0] omem_a [4];
   logic signed [15:0] mem_b [50];
   logic signed [15:0] omem_b [8];

   int         n_assert = 0;
   int         n_fail   = 0;
   int         wr_a, wr_b, dn_a;
   logic [5:0] max_b;
   int         lat, lat2;
   int         neg_exp;

   relu_maxpool2d #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_SIZE(4), .POOL(2)) dut_a (
      .clk(clk), .reset(reset), .start(start_a),
      .in_addr(in_addr_a), .in_en(in_en_a), .in_q(q_a),
      .out_addr(out_addr_a), .out_en(out_en_a), .out_we(out_we_a), .out_d(out_d_a),
      .done(done_a), .busy(busy_a)
   );

   relu_maxpool2d #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_SIZE(5), .POOL(2)) dut_b (
      .clk(clk), .reset(reset), .start(start_b),
      .in_addr(in_addr_b), .in_en(in_en_b), .in_q(q_b),
      .out_addr(out_addr_b), .out_en(out_en_b), .out_we(out_we_b), .out_d(out_d_b),
      .done(done_b), .busy(busy_b)
   );

   // BRAM models plus write/done/address bookkeeping.
   always @(posedge clk) begin
      if (in_en_a) q_a <= mem_a[in_addr_a];
      if (in_en_b) q_b <= mem_b[in_addr_b];
      if (clr) begin
         wr_a  <= 0;
         wr_b  <= 0;
         dn_a  <= 0;
         max_b <= '0;
         for (int i = 0; i < 4; i++) omem_a[i] <= 16'sh5A5A;
         for (int i = 0; i < 8; i++) omem_b[i] <= 16'sh5A5A;
      end else begin
         if (out_en_a && out_we_a) begin
            omem_a[out_addr_a] <= out_d_a;
            wr_a <= wr_a + 1;
         end
         if (out_en_b && out_we_b) begin
            omem_b[out_addr_b] <= out_d_b;
            wr_b <= wr_b + 1;
         end
         if (done_a) dn_a <= dn_a + 1;
         if (in_en_b && in_addr_b > max_b) max_b <= in_addr_b;
      end
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_tb();
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
   endtask

   // Pulse start and count negedges from the capturing edge until done is seen.
   task automatic run_a(output int n);
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      n = 1;
      while (!done_a && n < 1000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_b(output int n);
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      n = 1;
      while (!done_b && n < 1000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic fill_ramp_a();
      for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
   endtask

   task automatic check_ramp_a(input string tag);
      check({tag, "_o0"}, omem_a[0], 5);
      check({tag, "_o1"}, omem_a[1], 7);
      check({tag, "_o2"}, omem_a[2], 13);
      check({tag, "_o3"}, omem_a[3], 15);
   endtask

   initial begin
`ifdef RELU_MAXPOOL_RELU_EN
      neg_exp = 0;
`else
      neg_exp = -3;
`endif
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      clr     = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_done",     done_a,     0);
      check("rst_busy",     busy_a,     0);
      check("rst_in_en",    in_en_a,    0);
      check("rst_out_en",   out_en_a,   0);
      check("rst_out_we",   out_we_a,   0);
      check("rst_in_addr",  in_addr_a,  0);
      check("rst_out_addr", out_addr_a, 0);
      check("rst_out_d",    out_d_a,    0);
      reset = 1'b0;

      // Ramp 0..15: pooled {5,7,13,15}; 4 pixels * 13 cycles + 2 = 54.
      fill_ramp_a();
      clear_tb();
      run_a(lat);
      check("ramp_latency", lat, 54);
      check("ramp_busy_at_done", busy_a, 1);
      @(negedge clk);
      check("ramp_busy_after", busy_a, 0);
      check("ramp_done_pulse", done_a, 0);
      check("ramp_writes", wr_a, 4);
      check_ramp_a("ramp");

      // All -3: ReLU build writes 0, plain build passes -3 through.
      for (int i = 0; i < 16; i++) mem_a[i] = -16'sd3;
      clear_tb();
      run_a(lat);
      for (int i = 0; i < 4; i++) check($sformatf("neg3_o%0d", i), omem_a[i], neg_exp);

      // Extreme values in window 0; window 1 all negative (max -2); rest -100.
      for (int i = 0; i < 16; i++) mem_a[i] = -16'sd100;
      mem_a[0] = -16'sd32768;
      mem_a[1] = 16'sd32767;
      mem_a[4] = 16'sd0;
      mem_a[5] = -16'sd1;
      mem_a[2] = -16'sd5;
      mem_a[3] = -16'sd9;
      mem_a[6] = -16'sd2;
      mem_a[7] = -16'sd7;
      clear_tb();
      run_a(lat);
      check("ext_o0", omem_a[0], 32767);
`ifdef RELU_MAXPOOL_RELU_EN
      check("ext_o1", omem_a[1], 0);
      check("ext_o2", omem_a[2], 0);
`else
      check("ext_o1", omem_a[1], -2);
      check("ext_o2", omem_a[2], -100);
`endif

      // Reset 20 cycles into a frame, then a clean rerun.
      fill_ramp_a();
      clear_tb();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_out_we",   out_we_a,   0);
      check("abort_out_en",   out_en_a,   0);
      check("abort_in_en",    in_en_a,    0);
      check("abort_busy",     busy_a,     0);
      check("abort_done",     done_a,     0);
      check("abort_in_addr",  in_addr_a,  0);
      check("abort_out_addr", out_addr_a, 0);
      check("abort_out_d",    out_d_a,    0);
      reset = 1'b0;
      clear_tb();
      run_a(lat);
      check("rerun_latency", lat, 54);
      @(negedge clk);
      check("rerun_writes", wr_a, 4);
      check_ramp_a("rerun");

      // start held high: one done per frame, restart only from IDLE.
      clear_tb();
      @(negedge clk) start_a = 1'b1;
      lat = 0;
      while (!done_a && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
      check("held_latency1", lat, 54);
      lat2 = 0;
      @(negedge clk);
      lat2++;
      check("held_one_done", dn_a, 1);
      check("held_busy_restart", busy_a, 1);
      while (!done_a && lat2 < 1000) begin
         @(negedge clk);
         lat2++;
      end
      start_a = 1'b0;
      check("held_latency2", lat2, 54);
      repeat (60) @(negedge clk);
      check("held_two_dones", dn_a, 2);
      check("held_busy_idle", busy_a, 0);
      check("held_writes", wr_a, 8);

      // Two channels, 5x5: row/col 4 skipped, last tap (1,3,3) -> addr 43.
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 5; r++)
            for (int k = 0; k < 5; k++)
               mem_b[c*25 + r*5 + k] = 16'(r*5 + k + c*100);
      clear_tb();
      run_b(lat);
      check("b_latency", lat, 106);
      @(negedge clk);
      check("b_writes", wr_b, 8);
      check("b_max_in_addr", max_b, 43);
      check("b_o0", omem_b[0], 6);
      check("b_o1", omem_b[1], 8);
      check("b_o2", omem_b[2], 16);
      check("b_o3", omem_b[3], 18);
      check("b_o4", omem_b[4], 106);
      check("b_o5", omem_b[5], 108);
      check("b_o6", omem_b[6], 116);
      check("b_o7", omem_b[7], 118);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_relu_maxpool2d
`default_nettype wire
